outpass_pipe_frame_config_mux: RTL and testbench

- Parametrised successor to the fixed 4-bit optional-flop output pass BEL.
- Provides WIDTH independent fabric-to-external output channels.
- Each channel has a config-selected pipeline depth of 0–3 register stages and a config-selected output inversion.
- Adds a synchronous active-low reset and, optionally, a clock enable. Sits in RAM_IO-style tiles between the switch matrix and the EXTERNAL top-level pins.

---
 rtl/outpass_pipe_frame_config_mux.sv | 84 ++++++++
 tb/tb_outpass_pipe_frame_config_mux.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/outpass_pipe_frame_config_mux.sv
// outpass_pipe_frame_config_mux
// WIDTH independent fabric-to-pin output channels. Each channel has a
// frame-configured output tap (0..3 register stages) and an optional
// output inversion.
//
// Config layout, channel i:
//   ConfigBits[3i+1:3i] : DEPTH[i] (0 = combinational, 1..3 = S1..S3)
//   ConfigBits[3i+2]    : INV[i]
//
// Optional feature macro: OUTPASS_CE_EN
//   defined   : CE port exists; stages advance only on edges with CE=1
//   undefined : no CE port; stages advance on every edge
//
// NoConfigBits is not derived from WIDTH; it must be set to 3*WIDTH.

module outpass_pipe_frame_config_mux #(
    parameter int WIDTH        = 4,
    parameter int NoConfigBits = 12
) (
    input  logic                    UserCLK,
    input  logic                    UserRST_n,
    input  logic [WIDTH-1:0]        I,
`ifdef OUTPASS_CE_EN
    input  logic                    CE,
`endif
    output logic [WIDTH-1:0]        O,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    // Behavioural stand-in for one cus_mux21_buf cell: A0 is the lower tap,
    // A1 the higher tap, S comes from a config bit.
    function automatic logic cus_mux21_buf(input logic a0, input logic a1, input logic s);
        return s ? a1 : a0;
    endfunction

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3;
    logic             advance;

    logic [WIDTH-1:0] depth_lo;
    logic [WIDTH-1:0] depth_hi;
    logic [WIDTH-1:0] inv;
    logic [WIDTH-1:0] tap_lo;
    logic [WIDTH-1:0] tap_hi;
    logic [WIDTH-1:0] tap;

`ifdef OUTPASS_CE_EN
    assign advance = CE;
`else
    assign advance = 1'b1;
`endif

    // Stage shift: all three stages always move together; DEPTH only picks
    // which one reaches the pin. Reset wins over the advance enable.
    always_ff @(posedge UserCLK) begin
        if (!UserRST_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else if (advance) begin
            s1 <= I;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Per-channel config decode and 2-level mux tree to the output tap.
    // First level uses DEPTH[0] to pick within {I,S1} and {S2,S3}; second
    // level uses DEPTH[1] to choose between the pairs.
    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        assign depth_lo[g] = ConfigBits[3*g];
        assign depth_hi[g] = ConfigBits[3*g+1];
        assign inv[g]      = ConfigBits[3*g+2];

        assign tap_lo[g] = cus_mux21_buf(I[g],  s1[g], depth_lo[g]);
        assign tap_hi[g] = cus_mux21_buf(s2[g], s3[g], depth_lo[g]);
        assign tap[g]    = cus_mux21_buf(tap_lo[g], tap_hi[g], depth_hi[g]);

        // No output register: a reconfigured tap shows up immediately.
        assign O[g] = tap[g] ^ inv[g];
    end

endmodule

// File: tb/tb_outpass_pipe_frame_config_mux.sv
// Self-checking bench for outpass_pipe_frame_config_mux (WIDTH=8).
// Reference model keeps the last three advancing input samples and picks
// the one DEPTH edges old.

module tb_outpass_pipe_frame_config_mux;

    localparam int W  = 8;
    localparam int NC = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  i_data;
    logic [W-1:0]  o_data;
    logic [NC-1:0] cfg;
    logic          ce;

    int n_cmp = 0;
    int n_bad = 0;

    // hist[k] = input sample taken k+1 advancing edges ago
    logic [W-1:0] hist [0:2];

    always #5 clk = ~clk;

    outpass_pipe_frame_config_mux #(
        .WIDTH        (W),
        .NoConfigBits (NC)
    ) dut (
        .UserCLK    (clk),
        .UserRST_n  (rst_n),
        .I          (i_data),
`ifdef OUTPASS_CE_EN
        .CE         (ce),
`endif
        .O          (o_data),
        .ConfigBits (cfg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_o(input logic [W-1:0] din, input logic [NC-1:0] c);
        logic [W-1:0] r;
        int d;
        r = '0;
        for (int ch = 0; ch < W; ch++) begin
            d = int'(c[3*ch +: 2]);
            r[ch] = ((d == 0) ? din[ch] : hist[d-1][ch]) ^ c[3*ch+2];
        end
        return r;
    endfunction

    task automatic model_edge(input logic r, input logic [W-1:0] d, input logic cen);
        logic adv;
`ifdef OUTPASS_CE_EN
        adv = cen;
`else
        adv = 1'b1;
`endif
        if (!r) begin
            for (int k = 0; k < 3; k++) hist[k] = '0;
        end else if (adv) begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = d;
        end
    endtask

    // One cycle: drive at posedge+1, check mid-cycle, clock, update model.
    task automatic step(input string tag, input logic r, input logic [W-1:0] d,
                        input logic cen, input bit do_chk,
                        input bit use_exp, input logic [3:0] exp4);
        rst_n  = r;
        i_data = d;
        ce     = cen;
        #4;
        if (do_chk) chk(tag, 32'(o_data), 32'(model_o(i_data, cfg)));
        if (use_exp) chk({tag, "_lo4"}, 32'(o_data[3:0]), 32'(exp4));
        @(posedge clk);
        model_edge(r, d, cen);
        #1;
    endtask

    initial begin
        logic [NC-1:0] rcfg;
        logic          rr;
        logic          rce;
        rst_n  = 1'b0;
        i_data = '0;
        ce     = 1'b1;
        cfg    = '0;
        for (int k = 0; k < 3; k++) hist[k] = '0;
        @(posedge clk);
        #1;

        // Mixed config: ch0 d0, ch1 d1, ch2 d2, ch3 d3, no inversion.
        rcfg = NC'($urandom());
        cfg  = {rcfg[NC-1:12], 12'b011_010_001_000};
        step("rst0", 1'b0, '0, 1'b1, 1'b0, 1'b0, 4'h0);   // stages unknown before this edge
        step("rst1", 1'b0, '0, 1'b1, 1'b1, 1'b1, 4'h0);
        step("mix0", 1'b1, 8'h0F, 1'b1, 1'b1, 1'b1, 4'b0001);
        step("mix1", 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'b0010);
        step("mix2", 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'b0100);
        step("mix3", 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'b1000);
        step("mix4", 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'b0000);

        // Reset value reflects INV on registered taps.
        cfg = {8{3'b101}};
        step("rinv0", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'h0);
        step("rinv1", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'hF);

        // DEPTH=3 pulse on ch2: visible exactly three edges later for one cycle.
        cfg = {rcfg[NC-1:12], 12'b011_011_001_000};
        step("p3r", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'h0);
        step("p3a", 1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 4'b0000);
        step("p3b", 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'b0000);
        step("p3c", 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'b0000);
        step("p3d", 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'b0100);
        step("p3e", 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'b0000);

        // DEPTH=0 is purely combinational: no clock edge between checks.
        cfg[2:0] = 3'b000;
        i_data = 8'h00;
        #1 chk("comb_lo", 32'(o_data[0]), 32'd0);
        i_data = 8'h01;
        #1 chk("comb_hi", 32'(o_data[0]), 32'd1);
        cfg[2] = 1'b1;
        #1 chk("comb_inv", 32'(o_data[0]), 32'd0);
        step("comb_end", 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 4'h0);

        // Reset mid-stream with DEPTH=2 everywhere.
        cfg = {8{3'b010}};
        for (int k = 0; k < 6; k++)
            step("ms", 1'b1, (k % 2 == 0) ? 8'hFF : 8'h00, 1'b1, 1'b1, 1'b0, 4'h0);
        step("ms_rst", 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 4'h0);
        step("ms_r0", 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'h0);
        step("ms_r1", 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 4'h0);
        step("ms_r2", 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 4'h0);
        step("ms_r3", 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 4'hF);

`ifdef OUTPASS_CE_EN
        // CE gating with DEPTH=1 on ch1.
        cfg = {rcfg[NC-1:12], 12'b011_010_001_000};
        step("ce_r", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'h0);
        step("ce_h0", 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 4'b0000);
        step("ce_h1", 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 4'b0000);
        step("ce_h2", 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 4'b0000);
        step("ce_go", 1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 4'b0000);
        step("ce_rs", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'b0010);
        step("ce_cl", 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 4'b0000);
`endif

        // Random traffic with occasional reconfiguration and reset.
        cfg = NC'($urandom());
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 49) == 0) cfg = NC'($urandom());
            rr  = ($urandom_range(0, 39) != 0);
            rce = ($urandom_range(0, 3) != 0);
            step("rnd", rr, W'($urandom()), rce, 1'b1, 1'b0, 4'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
